// File: rtl/rx_frame_pkg.sv
// Shared state encoding, error codes and default framing constants for the
// receive frame controller.
package rx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    LENGTH   = 3'b001,
    PAYLOAD  = 3'b010,
    CHECKSUM = 3'b011,
    DONE     = 3'b100,
    ERROR    = 3'b101
  } state_e;

  localparam logic [1:0] ERR_PARITY  = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] HEADER_DEFAULT = 8'h7E;

endpackage

// File: rtl/rx_frame_timer.sv
// Inter-byte watchdog: counts while enabled and flags expiry once the count
// sits at TIMEOUT_TICKS-1; clear has priority over counting.
module rx_frame_timer #(
  parameter int TIMEOUT_TICKS = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             CW   = $clog2(TIMEOUT_TICKS);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_TICKS - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/rx_frame_ctrl.sv
// Frame assembler above the serial receiver: HEADER, LEN, payload, XOR checksum.
// Streams payload into an external buffer and offers good frames via valid/ack.
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter int         MAX_LEN       = 8,
  parameter logic [7:0] HEADER        = HEADER_DEFAULT,
  parameter int         TIMEOUT_TICKS = 50000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  input  logic                       parity_ok,
  input  logic                       frame_ack,
  output logic                       frame_valid,
  output logic [3:0]                 frame_len,
  output logic                       buf_wr_en,
  output logic [$clog2(MAX_LEN)-1:0] buf_wr_addr,
  output logic [7:0]                 buf_wr_data,
  output logic                       frame_error,
  output logic [1:0]                 error_code,
  output logic                       busy,
  output logic [2:0]                 db_estado
);

  localparam int         AW        = $clog2(MAX_LEN);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    chk_q, chk_d;
  logic [1:0]    err_q, err_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          frame_valid_q, frame_error_q, busy_q;
  logic [3:0]    frame_len_q;
  logic          timer_en, timer_clr, expired, last_byte;

  assign timer_en  = (state_q == LENGTH) || (state_q == PAYLOAD) || (state_q == CHECKSUM);
  assign timer_clr = byte_valid || !timer_en;
  assign last_byte = ({{(8-AW){1'b0}}, idx_q} == (len_q - 8'd1));

  rx_frame_timer #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clr),
    .enable  (timer_en),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    chk_d     = chk_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (byte_valid && parity_ok && (byte_data == HEADER)) state_d = LENGTH;
      end
      LENGTH: begin
        if (byte_valid) begin
          if (!parity_ok) begin
            state_d = ERROR;
            err_d   = ERR_PARITY;
          end else if ((byte_data == 8'h00) || (byte_data > MAX_LEN_B)) begin
            state_d = ERROR;
            err_d   = ERR_LEN;
          end else begin
            len_d   = byte_data;
            chk_d   = byte_data;
            idx_d   = '0;
            state_d = PAYLOAD;
          end
        end else if (expired) begin
          state_d = ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      PAYLOAD: begin
        if (byte_valid) begin
          if (!parity_ok) begin
            state_d = ERROR;
            err_d   = ERR_PARITY;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_data_d = byte_data;
            chk_d     = chk_q ^ byte_data;
            idx_d     = idx_q + 1'b1;
            if (last_byte) state_d = CHECKSUM;
          end
        end else if (expired) begin
          state_d = ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      CHECKSUM: begin
        if (byte_valid) begin
          if (!parity_ok) begin
            state_d = ERROR;
            err_d   = ERR_PARITY;
          end else if (byte_data != chk_q) begin
            state_d = ERROR;
            err_d   = ERR_CHK;
          end else begin
            state_d = DONE;
          end
        end else if (expired) begin
          state_d = ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      // Bytes seen while a frame is parked are dropped; only ack moves on.
      DONE:    if (frame_ack) state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from next-state so they line up with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      len_q         <= '0;
      chk_q         <= '0;
      err_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= '0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      chk_q         <= chk_d;
      err_q         <= err_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_valid_q <= (state_d == DONE);
      frame_len_q   <= (state_d == DONE) ? len_d[3:0] : 4'd0;
      frame_error_q <= (state_d == ERROR);
      busy_q        <= (state_d != IDLE);
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_len   = frame_len_q;
  assign buf_wr_en   = wr_en_q;
  assign buf_wr_addr = wr_addr_q;
  assign buf_wr_data = wr_data_q;
  assign frame_error = frame_error_q;
  assign error_code  = err_q;
  assign busy        = busy_q;
  assign db_estado   = state_q;

endmodule
